// File: rtl/bp_tlb_miss_ctrl_if.sv
// bp_tlb_miss_ctrl_if: requester, TLB and page-table-walker signals of the miss controller
interface bp_tlb_miss_ctrl_if #(
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 32,
  parameter int cnt_width_p   = 16
);
  logic                     flush_i;
  logic                     req_v_i;
  logic [vtag_width_p-1:0]  req_vtag_i;
  logic                     req_ready_o;
  logic                     resp_v_o;
  logic [entry_width_p-1:0] resp_entry_o;
  logic                     resp_fault_o;
  logic                     tlb_v_o;
  logic                     tlb_w_o;
  logic [vtag_width_p-1:0]  tlb_vtag_o;
  logic [entry_width_p-1:0] tlb_entry_o;
  logic                     tlb_flush_o;
  logic                     tlb_v_i;
  logic                     tlb_miss_v_i;
  logic [entry_width_p-1:0] tlb_entry_i;
  logic                     ptw_v_o;
  logic [vtag_width_p-1:0]  ptw_vtag_o;
  logic                     ptw_ready_i;
  logic                     ptw_v_i;
  logic [entry_width_p-1:0] ptw_entry_i;
  logic                     ptw_fault_i;
  logic [cnt_width_p-1:0]   miss_cnt_o;
  modport slave (
    input  flush_i, req_v_i, req_vtag_i, tlb_v_i, tlb_miss_v_i, tlb_entry_i,
           ptw_ready_i, ptw_v_i, ptw_entry_i, ptw_fault_i,
    output req_ready_o, resp_v_o, resp_entry_o, resp_fault_o, tlb_v_o, tlb_w_o,
           tlb_vtag_o, tlb_entry_o, tlb_flush_o, ptw_v_o, ptw_vtag_o, miss_cnt_o
  );
  modport master (
    output flush_i, req_v_i, req_vtag_i, tlb_v_i, tlb_miss_v_i, tlb_entry_i,
           ptw_ready_i, ptw_v_i, ptw_entry_i, ptw_fault_i,
    input  req_ready_o, resp_v_o, resp_entry_o, resp_fault_o, tlb_v_o, tlb_w_o,
           tlb_vtag_o, tlb_entry_o, tlb_flush_o, ptw_v_o, ptw_vtag_o, miss_cnt_o
  );
endinterface

// File: rtl/bp_tlb_miss_ctrl.sv
// bp_tlb_miss_ctrl: single-requester TLB lookup sequencer with page-walk refill
module bp_tlb_miss_ctrl #(
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 32,
  parameter int cnt_width_p   = 16
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_tlb_miss_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, FILL} state_e;
  state_e state_r, state_n;
  logic [vtag_width_p-1:0] vtag_r;
  logic [entry_width_p-1:0] entry_r;
  logic kill_r;
  logic [cnt_width_p-1:0] miss_cnt_r;
  logic accept, walk_done, walk_fault, lookup_hit, fill_wr;
  assign accept     = (state_r == IDLE) & bus.req_v_i & ~bus.flush_i;
  assign walk_done  = (state_r == WALK_WAIT) & bus.ptw_v_i;
  assign walk_fault = walk_done & bus.ptw_fault_i;
  assign lookup_hit = (state_r == LOOKUP) & bus.tlb_v_i;
  assign fill_wr    = (state_r == FILL) & ~kill_r;
  // state register
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= IDLE;
    else state_r <= state_n;
  // next-state selection
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:      state_n = accept ? LOOKUP : IDLE;
      LOOKUP:    state_n = bus.tlb_v_i ? IDLE : bus.tlb_miss_v_i ? WALK_REQ : LOOKUP;
      WALK_REQ:  state_n = bus.ptw_ready_i ? WALK_WAIT : WALK_REQ;
      WALK_WAIT: state_n = !bus.ptw_v_i ? WALK_WAIT : bus.ptw_fault_i ? IDLE : FILL;
      FILL:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  // request tag, walk result, flush-kill flag and saturating miss counter
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      vtag_r     <= '0;
      entry_r    <= '0;
      kill_r     <= 1'b0;
      miss_cnt_r <= '0;
    end else begin
      vtag_r     <= accept ? bus.req_vtag_i : vtag_r;
      entry_r    <= (walk_done & ~bus.ptw_fault_i) ? bus.ptw_entry_i : entry_r;
      kill_r     <= (state_n != IDLE) & (kill_r | (bus.flush_i & ((state_r == WALK_REQ) | (state_r == WALK_WAIT))));
      miss_cnt_r <= ((state_r == LOOKUP) & (state_n == WALK_REQ) & ~&miss_cnt_r) ? miss_cnt_r + cnt_width_p'(1) : miss_cnt_r;
    end
  // output decode; the fill write is suppressed once a flush hit the walk in flight
  always_comb begin
    bus.req_ready_o  = (state_r == IDLE) & ~bus.flush_i;
    bus.tlb_v_o      = accept | fill_wr;
    bus.tlb_w_o      = fill_wr;
    bus.tlb_vtag_o   = (state_r == IDLE) ? bus.req_vtag_i : vtag_r;
    bus.tlb_entry_o  = entry_r;
    bus.tlb_flush_o  = bus.flush_i;
    bus.ptw_v_o      = state_r == WALK_REQ;
    bus.ptw_vtag_o   = vtag_r;
    bus.resp_v_o     = lookup_hit | walk_fault | (state_r == FILL);
    bus.resp_fault_o = walk_fault;
    bus.resp_entry_o = lookup_hit ? bus.tlb_entry_i : (state_r == FILL) ? entry_r : '0;
    bus.miss_cnt_o   = miss_cnt_r;
  end
  a_lookup_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_r == LOOKUP) |-> (bus.tlb_v_i | bus.tlb_miss_v_i));
endmodule

// File: tb/tb_bp_tlb_miss_ctrl.sv
// tb_bp_tlb_miss_ctrl: randomized self-checking bench with TLB and walker environment models
module tb_bp_tlb_miss_ctrl;
  localparam int VW = 27;
  localparam int EW = 32;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [EW-1:0] env_data [64];
  logic [63:0] env_valid = '0;
  logic [EW-1:0] exp_data [64];
  logic [63:0] exp_valid = '0;
  always #5 clk = ~clk;
  bp_tlb_miss_ctrl_if #(.vtag_width_p(VW), .entry_width_p(EW), .cnt_width_p(CW)) bus ();
  bp_tlb_miss_ctrl #(.vtag_width_p(VW), .entry_width_p(EW), .cnt_width_p(CW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus));
  // environment TLB: answers reads one cycle later, applies flushes and writes
  always @(posedge clk) begin
    bus.tlb_v_i      <= bus.tlb_v_o & ~bus.tlb_w_o & (bus.tlb_vtag_o[VW-1:6] == '0) & env_valid[bus.tlb_vtag_o[5:0]];
    bus.tlb_miss_v_i <= bus.tlb_v_o & ~bus.tlb_w_o & ~((bus.tlb_vtag_o[VW-1:6] == '0) & env_valid[bus.tlb_vtag_o[5:0]]);
    bus.tlb_entry_i  <= env_valid[bus.tlb_vtag_o[5:0]] ? env_data[bus.tlb_vtag_o[5:0]] : '0;
    if (bus.tlb_flush_o) env_valid <= '0;
    if (bus.tlb_v_o & bus.tlb_w_o) begin
      env_valid[bus.tlb_vtag_o[5:0]] <= 1'b1;
      env_data[bus.tlb_vtag_o[5:0]]  <= bus.tlb_entry_o;
    end
  end
  task automatic txn(input logic [5:0] t, input int rdy, input int lat, input bit flt,
                     input logic [EW-1:0] pe, input bit fl);
    logic [VW-1:0] tag;
    bit killed;
    tag = {21'b0, t};
    killed = 1'b0;
    @(negedge clk);
    bus.req_v_i = 1'b1;
    bus.req_vtag_i = tag;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.tlb_v_o !== 1'b1 || bus.tlb_w_o !== 1'b0 || bus.tlb_vtag_o !== tag) begin
      errors++;
      $display("FAIL accept ready=%b v=%b w=%b tag=%h, want 1 1 0 %h", bus.req_ready_o, bus.tlb_v_o, bus.tlb_w_o, bus.tlb_vtag_o, tag);
    end
    @(negedge clk);
    bus.req_v_i = 1'b0;
    #1;
    if (exp_valid[t]) begin
      checks++;
      if (bus.resp_v_o !== 1'b1 || bus.resp_entry_o !== exp_data[t] || bus.resp_fault_o !== 1'b0 || bus.miss_cnt_o !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL hit tag=%h v=%b entry=%h fault=%b cnt=%0d, want 1 %h 0 %0d", tag, bus.resp_v_o, bus.resp_entry_o, bus.resp_fault_o, bus.miss_cnt_o, exp_data[t], exp_cnt);
      end
      return;
    end
    checks++;
    if (bus.resp_v_o !== 1'b0) begin
      errors++;
      $display("FAIL lookup_miss tag=%h resp_v=%b, want 0", tag, bus.resp_v_o);
    end
    exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
    for (int i = 0; i <= rdy; i++) begin
      @(negedge clk);
      bus.ptw_ready_i = (i == rdy);
      #1;
      checks++;
      if (bus.ptw_v_o !== 1'b1 || bus.ptw_vtag_o !== tag || bus.resp_v_o !== 1'b0 || bus.miss_cnt_o !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL walk_req ptw_v=%b vtag=%h resp_v=%b cnt=%0d, want 1 %h 0 %0d", bus.ptw_v_o, bus.ptw_vtag_o, bus.resp_v_o, bus.miss_cnt_o, tag, exp_cnt);
      end
    end
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      bus.ptw_ready_i = 1'b0;
      bus.flush_i = 1'b0;
      if (fl && i == 1 && lat > 1) begin
        bus.flush_i = 1'b1;
        killed = 1'b1;
        exp_valid = '0;
      end
      if (i == lat) begin
        bus.ptw_v_i = 1'b1;
        bus.ptw_entry_i = pe;
        bus.ptw_fault_i = flt;
      end
      #1;
      checks++;
      if (i < lat) begin
        if (bus.resp_v_o !== 1'b0 || bus.ptw_v_o !== 1'b0 || bus.tlb_flush_o !== bus.flush_i || bus.tlb_w_o !== 1'b0) begin
          errors++;
          $display("FAIL walk_wait resp_v=%b ptw_v=%b flush_o=%b w=%b, want 0 0 %b 0", bus.resp_v_o, bus.ptw_v_o, bus.tlb_flush_o, bus.tlb_w_o, bus.flush_i);
        end
      end else if (flt) begin
        if (bus.resp_v_o !== 1'b1 || bus.resp_fault_o !== 1'b1 || bus.resp_entry_o !== '0 || bus.tlb_w_o !== 1'b0) begin
          errors++;
          $display("FAIL fault_resp v=%b fault=%b entry=%h w=%b, want 1 1 0 0", bus.resp_v_o, bus.resp_fault_o, bus.resp_entry_o, bus.tlb_w_o);
        end
      end else if (bus.resp_v_o !== 1'b0) begin
        errors++;
        $display("FAIL walk_resp_cycle resp_v=%b, want 0", bus.resp_v_o);
      end
    end
    @(negedge clk);
    bus.ptw_v_i = 1'b0;
    bus.ptw_fault_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    checks++;
    if (flt) begin
      if (bus.req_ready_o !== 1'b1 || bus.resp_v_o !== 1'b0 || bus.tlb_w_o !== 1'b0) begin
        errors++;
        $display("FAIL after_fault ready=%b resp_v=%b w=%b, want 1 0 0", bus.req_ready_o, bus.resp_v_o, bus.tlb_w_o);
      end
    end else begin
      if (bus.resp_v_o !== 1'b1 || bus.resp_entry_o !== pe || bus.resp_fault_o !== 1'b0 ||
          bus.tlb_w_o !== !killed || bus.tlb_v_o !== !killed ||
          (!killed && (bus.tlb_vtag_o !== tag || bus.tlb_entry_o !== pe))) begin
        errors++;
        $display("FAIL fill v=%b entry=%h fault=%b tlb_v=%b w=%b vtag=%h wdata=%h, want 1 %h 0 %b %b %h %h",
                 bus.resp_v_o, bus.resp_entry_o, bus.resp_fault_o, bus.tlb_v_o, bus.tlb_w_o, bus.tlb_vtag_o, bus.tlb_entry_o,
                 pe, !killed, !killed, tag, pe);
      end
      if (!killed) begin
        exp_valid[t] = 1'b1;
        exp_data[t] = pe;
      end
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.resp_v_o !== 1'b0 || bus.resp_fault_o !== 1'b0 || bus.tlb_v_o !== 1'b0 || bus.tlb_w_o !== 1'b0 ||
        bus.ptw_v_o !== 1'b0 || bus.miss_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset resp_v=%b fault=%b tlb_v=%b w=%b ptw_v=%b cnt=%0d, want all 0", bus.resp_v_o, bus.resp_fault_o, bus.tlb_v_o, bus.tlb_w_o, bus.ptw_v_o, bus.miss_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready ready=%b, want 1", bus.req_ready_o);
    end
  endtask
  task automatic test_hit_and_miss();
    txn(6'h12, 0, 1, 1'b0, 32'hA5A5, 1'b0);
    txn(6'h12, 0, 1, 1'b0, 32'h0, 1'b0);
    txn(6'h34, 3, 5, 1'b0, 32'h1111, 1'b0);
    txn(6'h34, 0, 1, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_fault();
    txn(6'h16, 1, 2, 1'b1, 32'hDEAD, 1'b0);
    txn(6'h16, 0, 1, 1'b0, 32'h1616, 1'b0);
  endtask
  task automatic test_flush_walk();
    txn(6'h38, 0, 3, 1'b0, 32'h2222, 1'b1);
    txn(6'h38, 1, 2, 1'b0, 32'h3838, 1'b0);
    txn(6'h38, 0, 1, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_flush_idle();
    @(negedge clk);
    bus.flush_i = 1'b1;
    bus.req_v_i = 1'b1;
    bus.req_vtag_i = 27'h12;
    exp_valid = '0;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b0 || bus.tlb_flush_o !== 1'b1 || bus.tlb_v_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle ready=%b flush_o=%b tlb_v=%b, want 0 1 0", bus.req_ready_o, bus.tlb_flush_o, bus.tlb_v_o);
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.req_v_i = 1'b0;
    #1;
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.resp_v_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_after ready=%b resp_v=%b, want 1 0", bus.req_ready_o, bus.resp_v_o);
    end
  endtask
  task automatic test_reset_mid_walk();
    @(negedge clk);
    bus.req_v_i = 1'b1;
    bus.req_vtag_i = 27'h2A;
    @(negedge clk);
    bus.req_v_i = 1'b0;
    bus.ptw_ready_i = 1'b1;
    @(negedge clk);
    bus.ptw_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if (bus.resp_v_o !== 1'b0 || bus.resp_fault_o !== 1'b0 || bus.tlb_v_o !== 1'b0 || bus.tlb_w_o !== 1'b0 ||
        bus.ptw_v_o !== 1'b0 || bus.miss_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_walk resp_v=%b fault=%b tlb_v=%b w=%b ptw_v=%b cnt=%0d, want all 0", bus.resp_v_o, bus.resp_fault_o, bus.tlb_v_o, bus.tlb_w_o, bus.ptw_v_o, bus.miss_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.ptw_v_i = 1'b1;
    bus.ptw_entry_i = 32'h5555;
    #1;
    checks++;
    if (bus.resp_v_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.tlb_w_o !== 1'b0) begin
      errors++;
      $display("FAIL late_walk_resp resp_v=%b ready=%b w=%b, want 0 1 0", bus.resp_v_o, bus.req_ready_o, bus.tlb_w_o);
    end
    @(negedge clk);
    bus.ptw_v_i = 1'b0;
    #1;
    checks++;
    if (bus.resp_v_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after_late_resp resp_v=%b ready=%b, want 0 1", bus.resp_v_o, bus.req_ready_o);
    end
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 5; i++) txn(6'(32 + i), 0, 1, 1'b0, 32'(i + 100), 1'b0);
    @(negedge clk);
    checks++;
    if (bus.miss_cnt_o !== 2'd3) begin
      errors++;
      $display("FAIL saturation cnt=%0d, want 3", bus.miss_cnt_o);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++)
      txn(6'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
          ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 4) == 0));
  endtask
  initial begin
    bus.flush_i = 1'b0;
    bus.req_v_i = 1'b0;
    bus.req_vtag_i = '0;
    bus.ptw_ready_i = 1'b0;
    bus.ptw_v_i = 1'b0;
    bus.ptw_entry_i = '0;
    bus.ptw_fault_i = 1'b0;
    test_reset();
    test_hit_and_miss();
    test_fault();
    test_flush_walk();
    test_flush_idle();
    test_reset_mid_walk();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
